// File: rtl/tetris_ctrl_pkg.sv
// Shared types and default timing constants for the tetris game sequencer.
package tetris_ctrl_pkg;

  typedef enum logic [3:0] {
    PRE_GAME  = 4'd0,
    BUFFER    = 4'd1,
    LOAD      = 4'd2,
    SPAWN_CHK = 4'd3,
    WAIT      = 4'd4,
    DROP      = 4'd5,
    PAUSED    = 4'd6,
    UPDATE    = 4'd7,
    SCAN      = 4'd8,
    CLEAR     = 4'd9,
    GAME_OVER = 4'd10
  } state_t;

  localparam int DEF_BASE_PERIOD = 25000000;
  localparam int DEF_LEVEL_STEP  = 2500000;
  localparam int DEF_MIN_PERIOD  = 2500000;
  localparam int DEF_SOFT_PERIOD = 1250000;
  localparam int DEF_ROWS        = 20;

endpackage

// File: rtl/tetris_game_ctrl_if.sv
// Signal bundle between the game sequencer (master) and the board/block datapath (slave).
interface tetris_game_ctrl_if #(
  parameter int ROW_W   = 5,
  parameter int LINES_W = 10
);
  import tetris_ctrl_pkg::*;

  logic               start_game;
  logic               pause_btn;
  logic               soft_drop;
  logic               filled_under;
  logic               spawn_blocked;
  logic               row_full;
  // Command strobes are single-cycle pulses with no back-pressure: the datapath
  // acts on every cycle a strobe is high, and its status inputs are sampled on
  // the clock edge that ends that cycle.
  logic               load_block;
  logic               drop_block;
  logic               update_board_state;
  logic               clear_row;
  logic [ROW_W-1:0]   scan_row;
  logic               paused;
  logic               game_over;
  logic [3:0]         level;
  logic [LINES_W-1:0] lines_cleared;
  state_t             state;

  modport master (
    input  start_game, pause_btn, soft_drop, filled_under, spawn_blocked, row_full,
    output load_block, drop_block, update_board_state, clear_row, scan_row,
           paused, game_over, level, lines_cleared, state
  );

  modport slave (
    output start_game, pause_btn, soft_drop, filled_under, spawn_blocked, row_full,
    input  load_block, drop_block, update_board_state, clear_row, scan_row,
           paused, game_over, level, lines_cleared, state
  );
endinterface

// File: rtl/gravity_timer.sv
// Gravity counter: level-scaled period with a floor, soft-drop override, hold and clear.
module gravity_timer #(
  parameter int BASE_PERIOD = 25000000,
  parameter int LEVEL_STEP  = 2500000,
  parameter int MIN_PERIOD  = 2500000,
  parameter int SOFT_PERIOD = 1250000,
  parameter int TMR_W       = 25
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear,
  input  logic       run,
  input  logic       soft_drop,
  input  logic [3:0] level,
  output logic       expire
);
  logic [TMR_W-1:0] timer;
  logic [31:0]      reduction;
  logic [31:0]      period;

  // Compare before subtracting so a high level can never wrap the period.
  always_comb begin
    reduction = 32'(level) * 32'(LEVEL_STEP);
    if (32'(BASE_PERIOD) > reduction + 32'(MIN_PERIOD)) period = 32'(BASE_PERIOD) - reduction;
    else                                                 period = 32'(MIN_PERIOD);
    if (soft_drop && (32'(SOFT_PERIOD) < period))        period = 32'(SOFT_PERIOD);
  end

  assign expire = (32'(timer) >= (period - 32'd1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)    timer <= '0;
    else if (clear) timer <= '0;
    else if (run)   timer <= expire ? '0 : timer + TMR_W'(1);
  end
endmodule

// File: rtl/tetris_game_ctrl.sv
// Tetris game sequencer: spawn, gravity, pause, lock, row-by-row line clear and level tracking.
module tetris_game_ctrl
  import tetris_ctrl_pkg::*;
#(
  parameter int BASE_PERIOD     = DEF_BASE_PERIOD,
  parameter int LEVEL_STEP      = DEF_LEVEL_STEP,
  parameter int MIN_PERIOD      = DEF_MIN_PERIOD,
  parameter int SOFT_PERIOD     = DEF_SOFT_PERIOD,
  parameter int TMR_W           = 25,
  parameter int ROWS            = DEF_ROWS,
  parameter int ROW_W           = 5,
  parameter int MAX_LEVEL       = 9,
  parameter int LINES_PER_LEVEL = 10,
  parameter int LINES_W         = 10
) (
  input logic               clock,
  input logic               resetn,
  tetris_game_ctrl_if.master bus
);
  state_t             state;
  logic               pause_prev;
  logic               pause_edge;
  logic [ROW_W-1:0]   scan_row;
  logic [3:0]         level;
  logic [LINES_W-1:0] lines_cleared;
  logic [LINES_W-1:0] level_lines;
  logic               timer_clear;
  logic               timer_run;
  logic               expire;

  assign pause_edge  = bus.pause_btn & ~pause_prev;
  assign timer_clear = ((state == BUFFER) && !bus.start_game) || (state == SPAWN_CHK);
  // A pause edge in WAIT freezes the count, even on the expiry cycle.
  assign timer_run   = (state == WAIT) && !pause_edge;

  gravity_timer #(
    .BASE_PERIOD (BASE_PERIOD),
    .LEVEL_STEP  (LEVEL_STEP),
    .MIN_PERIOD  (MIN_PERIOD),
    .SOFT_PERIOD (SOFT_PERIOD),
    .TMR_W       (TMR_W)
  ) u_gravity (
    .clock     (clock),
    .resetn    (resetn),
    .clear     (timer_clear),
    .run       (timer_run),
    .soft_drop (bus.soft_drop),
    .level     (level),
    .expire    (expire)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= PRE_GAME;
      pause_prev    <= 1'b0;
      scan_row      <= '0;
      level         <= '0;
      lines_cleared <= '0;
      level_lines   <= '0;
    end else begin
      pause_prev <= bus.pause_btn;
      case (state)
        PRE_GAME:  if (bus.start_game) state <= BUFFER;
        BUFFER: if (!bus.start_game) begin
          level         <= '0;
          lines_cleared <= '0;
          level_lines   <= '0;
          state         <= LOAD;
        end
        LOAD:      state <= SPAWN_CHK;
        SPAWN_CHK: state <= bus.spawn_blocked ? GAME_OVER : WAIT;
        WAIT: begin
          if (pause_edge)  state <= PAUSED;
          else if (expire) state <= bus.filled_under ? UPDATE : DROP;
        end
        DROP:      state <= WAIT;
        PAUSED:    if (pause_edge) state <= WAIT;
        UPDATE: begin
          scan_row <= ROW_W'(ROWS - 1);
          state    <= SCAN;
        end
        SCAN: begin
          if (bus.row_full) state <= CLEAR;
          else if (scan_row == '0) begin
            scan_row <= '0;
            state    <= LOAD;
          end else scan_row <= scan_row - ROW_W'(1);
        end
        // The row above drops into scan_row, so SCAN re-tests the same row.
        CLEAR: begin
          if (lines_cleared != '1) lines_cleared <= lines_cleared + LINES_W'(1);
          if (level_lines == LINES_W'(LINES_PER_LEVEL - 1)) begin
            level_lines <= '0;
            if (level < 4'(MAX_LEVEL)) level <= level + 4'd1;
          end else level_lines <= level_lines + LINES_W'(1);
          state <= SCAN;
        end
        GAME_OVER: if (bus.start_game) state <= BUFFER;
        default:   state <= PRE_GAME;
      endcase
    end
  end

  assign bus.load_block         = (state == LOAD);
  assign bus.drop_block         = (state == DROP);
  assign bus.update_board_state = (state == UPDATE);
  assign bus.clear_row          = (state == CLEAR);
  assign bus.paused             = (state == PAUSED);
  assign bus.game_over          = (state == GAME_OVER);
  assign bus.scan_row           = scan_row;
  assign bus.level              = level;
  assign bus.lines_cleared      = lines_cleared;
  assign bus.state              = state;
endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Directed bench for tetris_game_ctrl with small periods; strobes are scored against a timed expectation queue.
module tb_tetris_game_ctrl;
  import tetris_ctrl_pkg::*;

  localparam int W = 40;
  localparam int K_LOAD = 0;
  localparam int K_DROP = 1;
  localparam int K_UPD  = 2;
  localparam int K_CLR  = 3;

  logic clock;
  logic resetn;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   base;
  int   lvl_tab [6] = '{1, 1, 2, 2, 3, 3};
  logic [W-1:0] exp_q[$];

  tetris_game_ctrl_if #(.ROW_W(2), .LINES_W(10)) bus ();

  tetris_game_ctrl #(
    .BASE_PERIOD(8), .LEVEL_STEP(2), .MIN_PERIOD(2), .SOFT_PERIOD(1), .TMR_W(4),
    .ROWS(4), .ROW_W(2), .MAX_LEVEL(3), .LINES_PER_LEVEL(2), .LINES_W(10)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [W-1:0] pack(input int kind, input int c, input int row,
                                        input int lvl, input int lines);
    return {kind[3:0], c[15:0], row[3:0], lvl[3:0], lines[11:0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int c, input int row, input int lvl, input int lines);
    exp_q.push_back(pack(kind, c, row, lvl, lines));
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    logic [W-1:0] got;
    logic [W-1:0] want;
    int kind;
    if (resetn === 1'b1 && (bus.load_block || bus.drop_block || bus.update_board_state || bus.clear_row)) begin
      kind = bus.load_block ? K_LOAD : bus.drop_block ? K_DROP : bus.update_board_state ? K_UPD : K_CLR;
      got  = pack(kind, cyc, int'(bus.scan_row), int'(bus.level), int'(bus.lines_cleared));
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: got kind=%0d cyc=%0d, want no strobe", kind, cyc);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL strobe: got kind=%0d cyc=%0d row=%0d lvl=%0d lines=%0d want kind=%0d cyc=%0d row=%0d lvl=%0d lines=%0d",
                   got[39:36], got[35:20], got[19:16], got[15:12], got[11:0],
                   want[39:36], want[35:20], want[19:16], want[15:12], want[11:0]);
        end
      end
    end
  end

  // driver
  initial begin
    resetn = 1'b1;
    bus.start_game = 0; bus.pause_btn = 0; bus.soft_drop = 0;
    bus.filled_under = 0; bus.spawn_blocked = 0; bus.row_full = 0;
    #2 resetn = 1'b0;
    repeat (3) tick();
    check("reset_state", bus.state, PRE_GAME);
    check("reset_strobes", {bus.load_block, bus.drop_block, bus.update_board_state, bus.clear_row}, 0);
    check("reset_regs", {bus.scan_row, bus.level, bus.lines_cleared}, 0);
    resetn = 1'b1;
    tick(); tick();
    check("idle_pre_game", bus.state, PRE_GAME);

    // start, then gravity drops every 9 cycles at level 0
    bus.start_game = 1; tick();
    check("buffer", bus.state, BUFFER);
    bus.start_game = 0; base = cyc;
    expect_ev(K_LOAD, base + 1, 0, 0, 0);
    expect_ev(K_DROP, base + 11, 0, 0, 0);
    expect_ev(K_DROP, base + 20, 0, 0, 0);
    repeat (20) tick();

    // pause at timer=5, hold 20 cycles, resume
    base = cyc;
    expect_ev(K_DROP, base + 30, 0, 0, 0);
    repeat (6) tick();
    bus.pause_btn = 1; tick();
    for (int i = 0; i < 20; i++) begin
      check("paused_hold", bus.paused, 1);
      if (i == 2)  bus.pause_btn = 0;
      if (i == 19) bus.pause_btn = 1;
      tick();
    end
    check("resumed", bus.paused, 0);
    bus.pause_btn = 0;
    repeat (3) tick();

    // lock and full scan without clears; pause edge in SCAN is ignored
    base = cyc; bus.filled_under = 1;
    expect_ev(K_UPD, base + 9, 0, 0, 0);
    expect_ev(K_LOAD, base + 14, 0, 0, 0);
    repeat (9) tick();
    bus.filled_under = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("scan_row_seq", bus.scan_row, 3 - i);
      check("scan_state", bus.state, SCAN);
      if (i == 0) bus.pause_btn = 1;
      if (i == 1) bus.pause_btn = 0;
    end
    tick();

    // two clears at row 2 -> level 1, interval 7
    base = cyc; bus.filled_under = 1;
    expect_ev(K_UPD,  base + 10, 0, 0, 0);
    expect_ev(K_CLR,  base + 13, 2, 0, 0);
    expect_ev(K_CLR,  base + 15, 2, 0, 1);
    expect_ev(K_LOAD, base + 19, 0, 1, 2);
    expect_ev(K_DROP, base + 27, 0, 1, 2);
    expect_ev(K_DROP, base + 34, 0, 1, 2);
    repeat (10) tick();
    bus.filled_under = 0;
    tick();
    check("scan_top", bus.scan_row, 3);
    tick();
    bus.row_full = 1;
    repeat (3) tick();
    bus.row_full = 0;
    tick();
    check("rescan_row", bus.scan_row, 2);
    check("lines_after_two", bus.lines_cleared, 2);
    check("level_after_two", bus.level, 1);
    repeat (18) tick();

    // soft drop: one WAIT cycle per drop
    base = cyc; bus.soft_drop = 1;
    expect_ev(K_DROP, base + 2, 0, 1, 2);
    expect_ev(K_DROP, base + 4, 0, 1, 2);
    expect_ev(K_DROP, base + 6, 0, 1, 2);
    repeat (6) tick();
    bus.soft_drop = 0;

    // six clears at row 3: level saturates at 3, period floors at 2
    base = cyc; bus.filled_under = 1;
    expect_ev(K_UPD, base + 7, 0, 1, 2);
    for (int i = 0; i < 6; i++) expect_ev(K_CLR, base + 9 + 2 * i, 3, lvl_tab[i], 2 + i);
    expect_ev(K_LOAD, base + 24, 0, 3, 8);
    expect_ev(K_DROP, base + 28, 0, 3, 8);
    expect_ev(K_DROP, base + 31, 0, 3, 8);
    repeat (7) tick();
    bus.filled_under = 0; bus.row_full = 1;
    repeat (12) tick();
    bus.row_full = 0;
    tick();
    check("level_saturated", bus.level, 3);
    check("lines_eight", bus.lines_cleared, 8);
    repeat (11) tick();

    // game over at spawn; level and lines held
    base = cyc; bus.filled_under = 1;
    expect_ev(K_UPD,  base + 3, 0, 3, 8);
    expect_ev(K_LOAD, base + 8, 0, 3, 8);
    repeat (3) tick();
    bus.filled_under = 0; bus.spawn_blocked = 1;
    repeat (7) tick();
    check("game_over", bus.game_over, 1);
    bus.spawn_blocked = 0;
    repeat (3) tick();
    check("game_over_hold", bus.state, GAME_OVER);
    check("level_held", bus.level, 3);
    check("lines_held", bus.lines_cleared, 8);

    // restart clears level/lines on leaving BUFFER
    bus.start_game = 1; tick();
    check("restart_buffer", bus.state, BUFFER);
    check("level_in_buffer", bus.level, 3);
    bus.start_game = 0; base = cyc;
    expect_ev(K_LOAD, base + 1, 0, 0, 0);
    expect_ev(K_UPD,  base + 11, 0, 0, 0);
    expect_ev(K_CLR,  base + 13, 3, 0, 0);
    tick();
    check("restart_level", bus.level, 0);
    check("restart_lines", bus.lines_cleared, 0);
    bus.filled_under = 1;
    repeat (10) tick();
    bus.filled_under = 0; bus.row_full = 1;
    repeat (4) tick();
    check("mid_clear", bus.clear_row, 1);
    check("mid_clear_lines", bus.lines_cleared, 1);

    // asynchronous reset in the middle of CLEAR
    resetn = 1'b0; bus.row_full = 0;
    #1;
    check("async_strobes", {bus.load_block, bus.drop_block, bus.update_board_state, bus.clear_row}, 0);
    check("async_status", {bus.paused, bus.game_over}, 0);
    check("async_regs", {bus.scan_row, bus.level, bus.lines_cleared}, 0);
    check("async_state", bus.state, PRE_GAME);
    tick();
    resetn = 1'b1;
    tick();
    check("post_reset_state", bus.state, PRE_GAME);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
